// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: single-outstanding bus master for the 16-bit SRAM/IO address map.
// Takes one read/write command at a time on a valid/ready port, runs
// SETUP -> ACCESS -> RESP on the bus with a per-region minimum wait and an
// ack timeout, and returns a one-cycle response. Addresses with the top bit
// set are unmapped and are answered with an error without touching the bus.
// Optional feature macro: MEM_BUS_INITIATOR_STATS_EN adds saturating
// transaction/error counters on outputs stat_txn and stat_err.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready for a command; address holds the last bus address
// S_SETUP  | address/data driven, strobes low, wait counter cleared
// S_ACCESS | strobe high; wait for minimum wait and ack, or timeout
// S_RESP   | one-cycle response for a completed or timed-out access
// S_ERR    | one-cycle error response for an unmapped address
module mem_bus_initiator #(
    parameter int N         = 4,
    parameter int SRAM_WAIT = 1,
    parameter int IO_WAIT   = 3,
    parameter int TIMEOUT   = 15   // must exceed IO_WAIT and SRAM_WAIT
) (
    input  logic             clk,
    input  logic             nRESET,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [N*4-1:0]   cmd_addr,
    input  logic [N*2-1:0]   cmd_wdata,
    output logic             rsp_valid,
    output logic [N*2-1:0]   rsp_rdata,
    output logic             rsp_err,
    output logic [N*4-1:0]   address,
    output logic [N*2-1:0]   bus_wdata,
    output logic             bus_rd,
    output logic             bus_wr,
    input  logic [N*2-1:0]   bus_rdata,
    input  logic             bus_ack,
    output logic             busy
`ifdef MEM_BUS_INITIATOR_STATS_EN
    ,
    output logic [15:0]      stat_txn,
    output logic [7:0]       stat_err
`endif
);

    localparam int AW = N * 4;
    localparam int DW = N * 2;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] C_TIMEOUT   = CW'(TIMEOUT);
    localparam logic [CW-1:0] C_SRAM_WAIT = CW'(SRAM_WAIT);
    localparam logic [CW-1:0] C_IO_WAIT   = CW'(IO_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;
    logic              r_write;
    logic [CW-1:0]     r_wait_cnt;
    logic [DW-1:0]     r_rsp_rdata;
    logic              r_rsp_err;
    logic [CW-1:0]     w_min_wait;
    logic              w_accept;
    logic              w_done;
    logic              w_timeout;

    // Bit AW-2 selects the IO half of the mapped space (slower responders).
    assign w_min_wait = r_addr[AW-2] ? C_IO_WAIT : C_SRAM_WAIT;
    assign w_accept   = (r_state == S_IDLE) && cmd_valid;
    assign w_done     = (r_state == S_ACCESS) && bus_ack && (r_wait_cnt >= w_min_wait);
    assign w_timeout  = (r_state == S_ACCESS) && !w_done && (r_wait_cnt == C_TIMEOUT);

    assign address    = r_addr;
    assign bus_wdata  = r_wdata;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err && rsp_valid;

    // State register.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        bus_rd       = 1'b0;
        bus_wr       = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_next_state = cmd_addr[AW-1] ? S_ERR : S_SETUP;
                end
            end
            S_SETUP: begin
                w_next_state = S_ACCESS;
            end
            S_ACCESS: begin
                bus_rd = !r_write;
                bus_wr = r_write;
                if (w_done || w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP, S_ERR: begin
                rsp_valid    = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Command capture, wait counter and response data.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_wait_cnt  <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                if (cmd_addr[AW-1]) begin
                    // Unmapped: leave the bus address untouched.
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                end else begin
                    r_addr  <= cmd_addr;
                    r_wdata <= cmd_wdata;
                    r_write <= cmd_write;
                end
            end
            if (r_state == S_SETUP) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_ACCESS) && (r_wait_cnt != C_TIMEOUT)) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
            if (w_done) begin
                r_rsp_rdata <= r_write ? '0 : bus_rdata;
                r_rsp_err   <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

`ifdef MEM_BUS_INITIATOR_STATS_EN
    logic [15:0] r_stat_txn;
    logic [7:0]  r_stat_err;

    assign stat_txn = r_stat_txn;
    assign stat_err = r_stat_err;

    // Saturating response and error counters.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_stat_txn <= '0;
            r_stat_err <= '0;
        end else if (rsp_valid) begin
            if (r_stat_txn != '1) begin
                r_stat_txn <= r_stat_txn + 16'd1;
            end
            if (rsp_err && (r_stat_err != '1)) begin
                r_stat_err <= r_stat_err + 8'd1;
            end
        end
    end
`endif

endmodule
